// File: rtl/mem_types.sv
// Memory controller command and state encodings.
// Shared by the controller and anything that drives it.
package mem_types;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        WRITE0 = 2'd2,
        WRITE1 = 2'd3
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR0  = 2'd2,
        S_WR1  = 2'd3
    } state_t;

    localparam int SRAM_AW = 19;

endpackage

// File: rtl/register_types.sv
// Register-level shared types.
// Byte address width seen by the memory controller.
package register_types;

    typedef logic [15:0] addr_t;

endpackage

// File: rtl/mem.sv
// Single-cycle-per-command async SRAM controller.
// Moore FSM with registered strobes and inline bus tri-state.
module mem
    import mem_types::*;
    import register_types::*;
(
    input  logic               clk,
    input  logic               reset,
    input  cmd_t               cmd,
    input  addr_t              addr,
    input  logic [7:0]         write_data,
    output logic [7:0]         read_data,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  wire  [7:0]         sram_data,
    output logic               sram_not_ce,
    output logic               sram_not_oe,
    output logic               sram_not_we
);

    state_t     state;
    state_t     state_nx;
    logic [7:0] wdata;
    logic       drive;
    logic       ce_nx;
    logic       oe_nx;
    logic       we_nx;
    logic       drive_nx;

    // Strobes are computed from the next state and registered with it,
    // so every SRAM pin comes straight off a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            sram_not_ce <= 1'b1;
            sram_not_oe <= 1'b1;
            sram_not_we <= 1'b1;
            drive       <= 1'b0;
            sram_addr   <= '0;
            wdata       <= '0;
            read_data   <= '0;
        end else begin
            state       <= state_nx;
            sram_not_ce <= ce_nx;
            sram_not_oe <= oe_nx;
            sram_not_we <= we_nx;
            drive       <= drive_nx;
            if (state_nx == S_RD || state_nx == S_WR0)
                sram_addr <= {3'b000, addr};
            if (state_nx == S_WR0)
                wdata <= write_data;
            if (state == S_RD)
                read_data <= sram_data;
        end
    end

    always_comb begin
        state_nx = S_IDLE;
        unique case (cmd)
            READ:    state_nx = S_RD;
            WRITE0:  state_nx = S_WR0;
            WRITE1:  state_nx = (state == S_WR0) ? S_WR1 : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        ce_nx    = 1'b1;
        oe_nx    = 1'b1;
        we_nx    = 1'b1;
        drive_nx = 1'b0;
        unique case (state_nx)
            S_RD: begin
                ce_nx = 1'b0;
                oe_nx = 1'b0;
            end
            S_WR0: begin
                ce_nx    = 1'b0;
                drive_nx = 1'b1;
            end
            S_WR1: begin
                ce_nx    = 1'b0;
                we_nx    = 1'b0;
                drive_nx = 1'b1;
            end
            default: begin
                ce_nx    = 1'b1;
                drive_nx = 1'b0;
            end
        endcase
    end

    assign sram_data = drive ? wdata : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_mem.sv
// Scoreboard bench for the SRAM controller.
// Expected pin states are queued per command and checked a cycle later.
module tb_mem;
    import mem_types::*;

    logic        clk;
    logic        reset;
    cmd_t        cmd;
    logic [15:0] addr;
    logic [7:0]  write_data;
    logic [7:0]  read_data;
    logic [18:0] sram_addr;
    wire  [7:0]  sram_data;
    logic        sram_not_ce;
    logic        sram_not_oe;
    logic        sram_not_we;

    int checks;
    int failures;

    mem dut (
        .clk         (clk),
        .reset       (reset),
        .cmd         (cmd),
        .addr        (addr),
        .write_data  (write_data),
        .read_data   (read_data),
        .sram_addr   (sram_addr),
        .sram_data   (sram_data),
        .sram_not_ce (sram_not_ce),
        .sram_not_oe (sram_not_oe),
        .sram_not_we (sram_not_we)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural SRAM: drives on read, stores mid-cycle while we_n is low.
    logic [7:0] sram_arr [256];
    assign sram_data = (!sram_not_ce && !sram_not_oe) ?
                       sram_arr[sram_addr[7:0]] : 8'bzzzz_zzzz;

    always @(negedge clk)
        if (!sram_not_ce && !sram_not_we)
            sram_arr[sram_addr[7:0]] = sram_data;

    typedef struct {
        logic        ce;
        logic        oe;
        logic        we;
        logic [18:0] addr;
        logic        drv;
        logic [7:0]  dval;
        logic [7:0]  rd;
    } exp_t;

    exp_t sb[$];

    // Reference model of what the pins should look like.
    localparam int M_IDLE = 0, M_RD = 1, M_WR0 = 2, M_WR1 = 3;
    int          m_state;
    logic [18:0] m_addr;
    logic [7:0]  m_wd;
    logic [7:0]  m_rd;
    logic [7:0]  exp_mem [256];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_addr  = '0;
        m_wd    = '0;
        m_rd    = '0;
        sb.delete();
    endtask

    task automatic do_cmd(input cmd_t c, input logic [15:0] a,
                          input logic [7:0] d);
        exp_t e;
        exp_t g;
        cmd        = c;
        addr       = a;
        write_data = d;
        if (m_state == M_WR1) exp_mem[m_addr[7:0]] = m_wd;
        if (m_state == M_RD)  m_rd = exp_mem[m_addr[7:0]];
        case (c)
            READ: begin
                m_state = M_RD;
                m_addr  = {3'b000, a};
            end
            WRITE0: begin
                m_state = M_WR0;
                m_addr  = {3'b000, a};
                m_wd    = d;
            end
            WRITE1: m_state = (m_state == M_WR0) ? M_WR1 : M_IDLE;
            default: m_state = M_IDLE;
        endcase
        e.ce   = (m_state == M_IDLE);
        e.oe   = (m_state != M_RD);
        e.we   = (m_state != M_WR1);
        e.addr = m_addr;
        e.drv  = (m_state == M_WR0 || m_state == M_WR1);
        e.dval = m_wd;
        e.rd   = m_rd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            g = sb.pop_front();
            chk("ce_n", sram_not_ce, g.ce);
            chk("oe_n", sram_not_oe, g.oe);
            chk("we_n", sram_not_we, g.we);
            chk("oe_we_low", !sram_not_oe && !sram_not_we, 0);
            chk("read_data", read_data, g.rd);
            if (!g.ce) chk("sram_addr", sram_addr, g.addr);
            if (g.drv) chk("sram_data", sram_data, g.dval);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 256; i++) begin
            sram_arr[i] = 8'h00;
            exp_mem[i]  = 8'h00;
        end
        sram_arr[8'h98] = 8'hA1;
        exp_mem[8'h98]  = 8'hA1;
        sram_arr[8'h40] = 8'h55;
        exp_mem[8'h40]  = 8'h55;

        cmd        = IDLE;
        addr       = '0;
        write_data = '0;
        reset      = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ce_n", sram_not_ce, 1);
        chk("rst_oe_n", sram_not_oe, 1);
        chk("rst_we_n", sram_not_we, 1);
        chk("rst_addr", sram_addr, 0);
        chk("rst_rd", read_data, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_ce_n", sram_not_ce, 1);
        chk("rel_addr", sram_addr, 0);

        do_cmd(READ, 16'h0098, 8'h00);
        do_cmd(IDLE, 16'h0000, 8'h00);
        chk("read_a1", read_data, 8'hA1);

        do_cmd(WRITE0, 16'h0098, 8'hBC);
        do_cmd(WRITE1, 16'h1234, 8'hFF);
        do_cmd(IDLE, 16'h0000, 8'h00);
        chk("wr_stored", sram_arr[8'h98], 8'hBC);
        do_cmd(READ, 16'h0098, 8'h00);
        do_cmd(IDLE, 16'h0000, 8'h00);
        chk("read_bc", read_data, 8'hBC);

        do_cmd(WRITE1, 16'h0098, 8'h00);
        do_cmd(WRITE1, 16'h0098, 8'h00);

        do_cmd(WRITE0, 16'h0040, 8'h99);
        do_cmd(IDLE, 16'h0000, 8'h00);
        do_cmd(READ, 16'h0040, 8'h00);
        do_cmd(IDLE, 16'h0000, 8'h00);
        chk("wr0_only", read_data, 8'h55);

        do_cmd(WRITE0, 16'h0041, 8'h3C);
        do_cmd(WRITE1, 16'h0000, 8'h00);
        do_cmd(READ, 16'h0041, 8'h00);
        do_cmd(WRITE0, 16'hFF42, 8'h5A);
        do_cmd(WRITE1, 16'h0000, 8'h00);
        do_cmd(READ, 16'hFF42, 8'h00);
        do_cmd(READ, 16'hFFFF, 8'h00);
        do_cmd(IDLE, 16'h0000, 8'h00);

        for (int i = 0; i < 60; i++) begin
            do_cmd(cmd_t'($urandom_range(3, 0)),
                   16'($urandom), 8'($urandom));
        end
        do_cmd(IDLE, 16'h0000, 8'h00);

        do_cmd(WRITE0, 16'h0010, 8'h77);
        do_cmd(WRITE1, 16'h0000, 8'h00);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_we_n", sram_not_we, 1);
        chk("abort_ce_n", sram_not_ce, 1);
        chk("abort_addr", sram_addr, 0);
        chk("abort_rd", read_data, 0);
        cmd = IDLE;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        do_cmd(READ, 16'h0010, 8'h00);
        do_cmd(IDLE, 16'h0000, 8'h00);
        chk("abort_nowrite", read_data, exp_mem[8'h10]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem.md
MEM -- requirements
Module: mem

Interface
REQ-001 One clock; reset is asynchronous and active-low: port clk is the clock and port reset is the reset, asserted at 0.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous reset, active-low.
REQ-004 cmd  input  mem_types::cmd_t  command, sampled each rising edge.
REQ-005 addr  input  register_types::addr_t (16 bits)  byte address.
REQ-006 write_data  input  8  byte to write.
REQ-007 read_data  output  8  last byte read.
REQ-008 sram_addr  output  19  SRAM address; addr zero-extended.
REQ-009 sram_data  inout  8  SRAM data bus; high-Z when not writing.
REQ-010 sram_not_ce  output  1  SRAM chip enable, active-low.
REQ-011 sram_not_oe  output  1  SRAM output enable, active-low.
REQ-012 sram_not_we  output  1  SRAM write enable, active-low.

Function
REQ-013 cmd_t SHALL be the enum IDLE, READ, WRITE0, WRITE1, with IDLE=0.
REQ-014 The controller SHALL be a Moore FSM with states S_IDLE, S_RD, S_WR0, S_WR1; the next state is set from cmd sampled at each rising edge.
REQ-015 S_IDLE: sram_not_ce=1, sram_not_oe=1, sram_not_we=1, sram_data high-Z.
REQ-016 READ SHALL enter S_RD for one cycle, latching sram_addr={3'b0,addr}, with sram_not_ce=0, sram_not_oe=0, sram_not_we=1 and sram_data high-Z.
REQ-017 At the rising edge that ends S_RD, read_data SHALL capture sram_data; latency is one cycle from the READ sample edge to S_RD, and two cycles to read_data valid.
REQ-018 read_data SHALL hold its value until the next completed read.
REQ-019 WRITE0 SHALL enter S_WR0, latching sram_addr={3'b0,addr} and write_data into an internal register, with sram_not_ce=0, sram_not_oe=1, sram_not_we=1 and sram_data driven with the latched byte (address/data setup).
REQ-020 WRITE1 taken from S_WR0 SHALL enter S_WR1: sram_not_we=0, sram_not_ce=0, sram_not_oe=1, same latched address and data driven; addr and write_data are ignored.
REQ-021 WRITE1 sampled in any state other than S_WR0 SHALL be treated as IDLE; no write strobe is issued.
REQ-022 Leaving S_WR1, sram_not_we and the data drive SHALL be released on the same edge; the target SRAM has zero data-hold time.
REQ-023 sram_data SHALL be driven only in S_WR0 and S_WR1; sram_not_oe and sram_not_we SHALL never be low simultaneously.
REQ-024 All SRAM strobes and sram_addr SHALL be registered outputs (glitch-free).
REQ-025 Back-to-back commands SHALL be accepted every cycle with no busy state; each command occupies exactly one cycle.
REQ-026 A WRITE0 not followed by WRITE1 SHALL leave SRAM contents unchanged.

Reset
REQ-027 While reset=0: state S_IDLE, all strobes 1, sram_addr=0, read_data=0, write-data register=0, sram_data high-Z.
REQ-028 Reset asserted mid-operation, including in S_WR1, SHALL abort immediately and asynchronously, raising sram_not_we.
REQ-029 The first command is sampled at the first rising edge after reset deasserts.

Structure
REQ-030 cmd_t SHALL reside in package mem_types.
REQ-031 addr_t SHALL reside in package register_types.
REQ-032 The block SHALL be a single module with no sub-modules; the bus tri-state is inline.

Verification
REQ-033 Reset low, then release: all strobes=1, sram_addr=0, read_data=0, sram_data=Z.
REQ-034 WRITE0, addr=0x98, write_data=0xBC: next cycle sram_addr=0x00098, ce_n=0, we_n=1, oe_n=1, sram_data=0xBC.
REQ-035 WRITE1 following that WRITE0: we_n=0 for exactly one cycle, with sram_data=0xBC and sram_addr=0x00098 unchanged.
REQ-036 READ, addr=0x98, SRAM model drives 0xA1 when oe_n=0: oe_n=0 and ce_n=0 for one cycle, then read_data=0xA1.
REQ-037 WRITE1 from S_IDLE: we_n stays 1 and ce_n stays 1.
REQ-038 Reset asserted during S_WR1: we_n=1 immediately, before the next clock edge.
